stopwatch_cu: RTL and testbench
===============================

Name: stopwatch_cu

Overview:
- Control unit directly downstream of the button debouncers.
- Consumes their one-cycle rising-edge pulses, plus command bytes from the UART receiver.
- Produces the run, clear and display-mode controls for the stopwatch datapath.
- Buttons and UART commands are merged into one event stream that drives a STOP/RUN/CLEAR state machine and a mode toggle.

Parameters:
- CMD_RUN, 8'h52, ASCII 'R': run/stop toggle command.
- CMD_CLEAR, 8'h43, ASCII 'C': clear command.
- CMD_MODE, 8'h4D, ASCII 'M': display-mode toggle command.
- CASE_INSENS, 1: when 1, compare command bytes with bit 5 masked, so 'r'/'c'/'m' are also accepted.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- i_btn_run  in  1  debounced run/stop pulse, one clk cycle wide.
- i_btn_clear  in  1  debounced clear pulse, one clk cycle wide.
- i_btn_mode  in  1  debounced mode pulse, one clk cycle wide.
- i_rx_done  in  1  UART byte-valid strobe, one clk cycle wide.
- i_rx_data  in  8  UART received byte; valid only while i_rx_done=1.
- o_run  out  1  level: 1 while the stopwatch counts.
- o_clear  out  1  one-cycle clear pulse to the counters.
- o_mode  out  1  level: 0=min:sec:centisec, 1=hour:min:sec.
- o_cmd_ack  out  1  one-cycle pulse: UART byte recognised as a command.
- o_cmd_err  out  1  one-cycle pulse: UART byte not recognised.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = STOP.
  - o_run=0, o_clear=0, o_mode=0, o_cmd_ack=0, o_cmd_err=0.
  - Release is synchronous to the next clk edge.
- Decode (combinational, only when i_rx_done=1):
  - rx_run/rx_clear/rx_mode = the byte equals the corresponding CMD_* (bit 5 masked if CASE_INSENS).
  - Any other byte sets rx_err.
- Events:
  - run_evt = i_btn_run | rx_run.
  - clr_evt = i_btn_clear | rx_clear.
  - mode_evt = i_btn_mode | rx_mode.
  - A button pulse and a matching UART command in the same cycle count as ONE event. No double toggle.
- State machine (registered, Moore outputs):
  - STOP: clr_evt -> CLEAR. Otherwise run_evt -> RUN. Otherwise stay.
  - RUN: run_evt -> STOP. clr_evt is ignored (no clear while counting). Otherwise stay.
  - CLEAR: unconditional -> STOP after exactly one cycle. All events arriving in this cycle are dropped.
- Simultaneous run_evt and clr_evt in STOP: clear wins, run is dropped.
- Outputs and latency:
  - o_run = (state==RUN).
  - o_clear = (state==CLEAR).
  - Event in cycle N -> output change visible in cycle N+1.
  - o_clear is high for exactly 1 cycle per accepted clear.
- Mode:
  - o_mode toggles on mode_evt in STOP or RUN. Ignored in CLEAR.
  - Latency 1 cycle.
  - Independent of run/clear in the same cycle, e.g. run+mode in STOP -> RUN and mode toggled together.
- Ack/err:
  - o_cmd_ack is registered, 1 cycle after i_rx_done whenever the byte decodes to any command, even if the FSM ignores it (e.g. 'C' while RUN).
  - o_cmd_err is registered, 1 cycle after i_rx_done for an unrecognised byte.
  - ack and err are mutually exclusive.
  - Both stay 0 when i_rx_done=0, whatever i_rx_data holds.
- Back-to-back events on consecutive cycles are each evaluated against the current state. No queuing.
- Reset mid-RUN or mid-CLEAR: immediate return to reset values. A clear pulse cut short by reset is not re-issued.

Decomposition:
- Shared package, stopwatch_pkg:
  - State encoding: STOP=2'b00, RUN=2'b01, CLEAR=2'b10. The unused code 2'b11 recovers to STOP.
  - ASCII command constants, reused by the UART TX echo logic.
- One natural sub-module: uart_cmd_decoder.
  - Inputs: i_rx_done, i_rx_data, CASE_INSENS.
  - Outputs: rx_run, rx_clear, rx_mode, rx_err (combinational).
- The FSM, mode register and ack/err registers stay in stopwatch_cu.

Test Plan:
- Reset released, no input -> o_run=0, o_mode=0, o_clear never pulses for 100 cycles.
- i_btn_run pulse at cycle 10 -> o_run=1 from cycle 11. Second pulse at cycle 50 -> o_run=0 from cycle 51.
- In STOP, i_rx_done with 8'h63 ('c') -> o_clear=1 for exactly one cycle, o_cmd_ack one pulse, then STOP. In RUN, 8'h43 -> o_run stays 1, no o_clear, o_cmd_ack still pulses.
- In STOP, i_btn_run and i_btn_clear in the same cycle -> one o_clear pulse, o_run stays 0. Then i_btn_run together with rx 'R' in one cycle -> o_run=1, and only a single toggle occurs.
- i_rx_done with 8'h58 ('X') -> o_cmd_err one pulse, o_cmd_ack=0, state and o_mode unchanged. 'M' while RUN -> o_mode=1, o_run still 1.
- In RUN, drive reset=0 asynchronously mid-cycle -> o_run=0 immediately, without waiting for a clk edge. After release, i_btn_run -> o_run=1 next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding and ASCII command bytes for the stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } sw_state_t;

    localparam logic [7:0] C_CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] C_CMD_CLEAR = 8'h43;  // 'C'
    localparam logic [7:0] C_CMD_MODE  = 8'h4D;  // 'M'

    localparam logic [7:0] C_CASE_MASK = 8'hDF;  // clears the ASCII lower-case bit

endpackage

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Classifies a received UART byte as run/clear/mode command or error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] CMD_RUN     = C_CMD_RUN,
    parameter logic [7:0] CMD_CLEAR   = C_CMD_CLEAR,
    parameter logic [7:0] CMD_MODE    = C_CMD_MODE,
    parameter bit         CASE_INSENS = 1'b1
) (
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_run,
    output logic       o_rx_clear,
    output logic       o_rx_mode,
    output logic       o_rx_err
);

    logic [7:0] w_mask;
    logic [7:0] w_byte;
    logic       w_hit_run;
    logic       w_hit_clear;
    logic       w_hit_mode;

    generate
        if (CASE_INSENS) begin : g_case_insens
            assign w_mask = C_CASE_MASK;
        end else begin : g_case_exact
            assign w_mask = 8'hFF;
        end
    endgenerate

    assign w_byte      = i_rx_data & w_mask;
    assign w_hit_run   = (w_byte == (CMD_RUN   & w_mask));
    assign w_hit_clear = (w_byte == (CMD_CLEAR & w_mask));
    assign w_hit_mode  = (w_byte == (CMD_MODE  & w_mask));

    // Data is meaningless outside the strobe, so every output is gated by it.
    assign o_rx_run   = i_rx_done & w_hit_run;
    assign o_rx_clear = i_rx_done & w_hit_clear;
    assign o_rx_mode  = i_rx_done & w_hit_mode;
    assign o_rx_err   = i_rx_done & ~(w_hit_run | w_hit_clear | w_hit_mode);

endmodule

`default_nettype wire

// File: rtl/stopwatch_cu.sv
// ============================================================================
// Module      : stopwatch_cu
// Description : Merges button pulses and UART commands into STOP/RUN/CLEAR control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] CMD_RUN     = C_CMD_RUN,
    parameter logic [7:0] CMD_CLEAR   = C_CMD_CLEAR,
    parameter logic [7:0] CMD_MODE    = C_CMD_MODE,
    parameter bit         CASE_INSENS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_mode,
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_data,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_mode,
    output logic       o_cmd_ack,
    output logic       o_cmd_err
);

    sw_state_t state_q, state_d;
    logic      mode_q, mode_d;
    logic      ack_q, ack_d;
    logic      err_q, err_d;

    logic w_rx_run, w_rx_clear, w_rx_mode, w_rx_err;
    logic w_run_evt, w_clr_evt, w_mode_evt;

    uart_cmd_decoder #(
        .CMD_RUN     (CMD_RUN),
        .CMD_CLEAR   (CMD_CLEAR),
        .CMD_MODE    (CMD_MODE),
        .CASE_INSENS (CASE_INSENS)
    ) u_decoder (
        .i_rx_done  (i_rx_done),
        .i_rx_data  (i_rx_data),
        .o_rx_run   (w_rx_run),
        .o_rx_clear (w_rx_clear),
        .o_rx_mode  (w_rx_mode),
        .o_rx_err   (w_rx_err)
    );

    // OR-merge so a button and a matching UART command in one cycle act once.
    assign w_run_evt  = i_btn_run   | w_rx_run;
    assign w_clr_evt  = i_btn_clear | w_rx_clear;
    assign w_mode_evt = i_btn_mode  | w_rx_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
            mode_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = ST_STOP;
        mode_d  = mode_q;
        ack_d   = w_rx_run | w_rx_clear | w_rx_mode;
        err_d   = w_rx_err;

        case (state_q)
            ST_STOP: begin
                if (w_clr_evt)      state_d = ST_CLEAR;
                else if (w_run_evt) state_d = ST_RUN;
                else                state_d = ST_STOP;
                if (w_mode_evt)     mode_d  = ~mode_q;
            end
            ST_RUN: begin
                state_d = w_run_evt ? ST_STOP : ST_RUN;
                if (w_mode_evt)     mode_d  = ~mode_q;
            end
            ST_CLEAR: begin
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    assign o_run     = (state_q == ST_RUN);
    assign o_clear   = (state_q == ST_CLEAR);
    assign o_mode    = mode_q;
    assign o_cmd_ack = ack_q;
    assign o_cmd_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_cu.sv
// ============================================================================
// Module      : tb_stopwatch_cu
// Description : Directed self-checking bench for stopwatch_cu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_cu;

    logic       clk;
    logic       reset;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_mode;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       o_run;
    logic       o_clear;
    logic       o_mode;
    logic       o_cmd_ack;
    logic       o_cmd_err;

    int vectors;
    int miscompares;

    stopwatch_cu dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_mode  (i_btn_mode),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .o_run       (o_run),
        .o_clear     (o_clear),
        .o_mode      (o_mode),
        .o_cmd_ack   (o_cmd_ack),
        .o_cmd_err   (o_cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check all five outputs at once.
    task automatic chk_all(input string tag, input logic run, input logic clr,
                           input logic mode, input logic ack, input logic err);
        chk({tag, ".run"},   o_run,     run);
        chk({tag, ".clear"}, o_clear,   clr);
        chk({tag, ".mode"},  o_mode,    mode);
        chk({tag, ".ack"},   o_cmd_ack, ack);
        chk({tag, ".err"},   o_cmd_err, err);
    endtask

    // Clock the currently driven inputs in, then drop all pulses 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_mode  = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'h00;
    endtask

    task automatic send_rx(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_mode  = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'h00;

        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle.run",   o_run,   1'b0);
            chk("idle.clear", o_clear, 1'b0);
        end
        chk("idle.mode", o_mode, 1'b0);

        // Button run toggles RUN on, then off again after a long gap.
        i_btn_run = 1'b1;
        step();
        chk_all("btn_run_on", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (39) step();
        chk("run_hold", o_run, 1'b1);
        i_btn_run = 1'b1;
        step();
        chk_all("btn_run_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lower-case 'c' in STOP clears for one cycle.
        send_rx(8'h63);
        step();
        chk_all("rx_c_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("rx_c_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 'C' while RUN is acknowledged but ignored by the FSM.
        i_btn_run = 1'b1;
        step();
        chk("to_run", o_run, 1'b1);
        send_rx(8'h43);
        step();
        chk_all("rx_C_run", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        i_btn_clear = 1'b1;
        step();
        chk_all("btn_clr_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        i_btn_run = 1'b1;
        step();
        chk("to_stop", o_run, 1'b0);

        // Run and clear together in STOP: clear wins.
        i_btn_run   = 1'b1;
        i_btn_clear = 1'b1;
        step();
        chk_all("run_clr_stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("run_clr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Button plus 'R' in one cycle toggles only once.
        i_btn_run = 1'b1;
        send_rx(8'h52);
        step();
        chk_all("btn_rx_run", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("single_toggle", o_run, 1'b1);

        // Unknown byte 'X' flags an error only.
        send_rx(8'h58);
        step();
        chk_all("rx_X", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 'M' while RUN toggles mode, run unaffected.
        send_rx(8'h4D);
        step();
        chk_all("rx_M_run", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Data without the strobe is ignored.
        i_rx_data = 8'h52;
        step();
        chk_all("no_strobe", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back to STOP, then clear; events during CLEAR are dropped.
        i_btn_run = 1'b1;
        step();
        chk("stop_again", o_run, 1'b0);
        i_btn_clear = 1'b1;
        step();
        chk("clear_again", o_clear, 1'b1);
        i_btn_mode = 1'b1;
        i_btn_run  = 1'b1;
        step();
        chk_all("evts_in_clear", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Run plus mode in STOP act together.
        i_btn_run  = 1'b1;
        i_btn_mode = 1'b1;
        step();
        chk_all("run_mode_stop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lower-case 'm' is accepted.
        send_rx(8'h6D);
        step();
        chk_all("rx_m_lower", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back run pulses each toggle against the current state.
        i_btn_run = 1'b1;
        step();
        chk("b2b_1", o_run, 1'b0);
        i_btn_run = 1'b1;
        step();
        chk("b2b_2", o_run, 1'b1);

        // Asynchronous reset mid-RUN takes effect without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step();
        chk("post_rst_idle", o_run, 1'b0);
        i_btn_run = 1'b1;
        step();
        chk("post_rst_run", o_run, 1'b1);
        i_btn_run = 1'b1;
        step();
        chk("post_rst_stop", o_run, 1'b0);

        // Reset mid-CLEAR cuts the pulse and does not reissue it.
        i_btn_clear = 1'b1;
        step();
        chk("pre_rst_clear", o_clear, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_clear", o_clear, 1'b0);
        #2;
        reset = 1'b1;
        step();
        chk_all("after_rst_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
